// File: rtl/stopwatch_bcd_core.sv
// Parametrised BCD stopwatch/timer core: NF two-digit BCD fields, field 0 is
// seconds. Lower fields count 00..59 and the top field counts 00..TOP_MAX.
// Supports up/down counting, per-field adjust, preload with sanitising,
// countdown-done and a lap-freeze display register.
//
// state | meaning
// ------+---------------------------------------------------------------
// STOP  | count held, waiting for pause_tgl (start) or load
// RUN   | count steps on every tick_run, up or down depending on dir
// ADJ   | adj held high; tick_adj steps field sel without carry/borrow
// DONE  | countdown expired; count held at zero until pause_tgl or load
module stopwatch_bcd_core #(
   parameter int NF      = 2,
   parameter int TOP_MAX = 99,
   parameter int SELW    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tick_run,
   input  logic            tick_adj,
   input  logic            pause_tgl,
   input  logic            adj,
   input  logic [SELW-1:0] sel,
   input  logic            dir,
   input  logic            load,
   input  logic [8*NF-1:0] load_val,
   input  logic            lap,
   output logic [8*NF-1:0] count,
   output logic [8*NF-1:0] disp,
   output logic            running,
   output logic            lap_hold,
   output logic            wrap,
   output logic            done
);

   localparam int W = 8*NF;
   localparam logic [7:0] TOP_MAX_BCD = 8'(((TOP_MAX / 10) << 4) | (TOP_MAX % 10));

   typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_ADJ, ST_DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   disp_q, disp_d;
   logic           lap_hold_q, lap_hold_d;
   logic           wrap_q, wrap_d;
   logic           done_q, done_d;

   // BCD maximum of field i: 59 for the base-60 fields, TOP_MAX for the top one.
   function automatic logic [7:0] field_max(input int i);
      return (i == NF-1) ? TOP_MAX_BCD : 8'h59;
   endfunction

   // Increment within 0..mx; returns 0 when already at mx.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
      if (v == mx)
         return 8'h00;
      if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Decrement within 0..mx; returns mx when already at 0.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
      if (v == 8'h00)
         return mx;
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   // Non-BCD digits or out-of-range values saturate to the field maximum.
   // For valid BCD, a plain unsigned compare orders values correctly.
   function automatic logic [7:0] bcd_sanitise(input logic [7:0] v, input logic [7:0] mx);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
         return mx;
      if (v > mx)
         return mx;
      return v;
   endfunction

   // Next-state, count and one-cycle pulse logic, in priority order adj > load > pause > tick.
   always_comb begin
      logic       cy;
      logic [7:0] fld;
      state_d = state_q;
      count_d = count_q;
      wrap_d  = 1'b0;
      done_d  = 1'b0;
      cy      = 1'b1;
      fld     = 8'h00;

      if (adj) begin
         state_d = ST_ADJ;
         if (state_q == ST_ADJ && tick_adj) begin
            for (int i = 0; i < NF; i++) begin
               if (int'(sel) == i) begin
                  count_d[8*i +: 8] = dir ? bcd_dec(count_q[8*i +: 8], field_max(i))
                                          : bcd_inc(count_q[8*i +: 8], field_max(i));
               end
            end
         end
      end else if (state_q == ST_ADJ) begin
         state_d = ST_STOP;
      end else if (load && (state_q == ST_STOP || state_q == ST_DONE)) begin
         for (int i = 0; i < NF; i++)
            count_d[8*i +: 8] = bcd_sanitise(load_val[8*i +: 8], field_max(i));
         state_d = ST_STOP;
      end else if (pause_tgl) begin
         case (state_q)
            ST_STOP: state_d = ST_RUN;
            ST_RUN:  state_d = ST_STOP;
            ST_DONE: state_d = ST_STOP;
            default: state_d = state_q;
         endcase
      end else if (tick_run && state_q == ST_RUN) begin
         if (!dir) begin
            for (int i = 0; i < NF; i++) begin
               if (cy) begin
                  fld = count_q[8*i +: 8];
                  count_d[8*i +: 8] = bcd_inc(fld, field_max(i));
                  cy = (fld == field_max(i));
               end
            end
            // Carry out of the top field means every field was at its max.
            wrap_d = cy;
         end else if (count_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end else begin
            for (int i = 0; i < NF; i++) begin
               if (cy) begin
                  fld = count_q[8*i +: 8];
                  count_d[8*i +: 8] = bcd_dec(fld, field_max(i));
                  cy = (fld == 8'h00);
               end
            end
         end
      end
   end

   // Lap toggle and display capture; the display freezes while lap_hold is set.
   always_comb begin
      lap_hold_d = lap ? ~lap_hold_q : lap_hold_q;
      disp_d     = lap_hold_q ? disp_q : count_q;
   end

   // All state registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_STOP;
         count_q    <= '0;
         disp_q     <= '0;
         lap_hold_q <= 1'b0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         disp_q     <= disp_d;
         lap_hold_q <= lap_hold_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
      end
   end

   assign count    = count_q;
   assign disp     = disp_q;
   assign running  = (state_q == ST_RUN);
   assign lap_hold = lap_hold_q;
   assign wrap     = wrap_q;
   assign done     = done_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Directed bench for stopwatch_bcd_core with NF=2 (mm:ss), TOP_MAX=99.
module tb_stopwatch_bcd_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick_run, tick_adj, pause_tgl, adj, dir, load, lap;
   logic [1:0]  sel;
   logic [15:0] load_val;
   logic [15:0] count, disp;
   logic        running, lap_hold, wrap, done;

   int checks   = 0;
   int failures = 0;

   stopwatch_bcd_core #(.NF(2), .TOP_MAX(99), .SELW(2)) dut (
      .clk(clk), .rst(rst), .tick_run(tick_run), .tick_adj(tick_adj),
      .pause_tgl(pause_tgl), .adj(adj), .sel(sel), .dir(dir), .load(load),
      .load_val(load_val), .lap(lap), .count(count), .disp(disp),
      .running(running), .lap_hold(lap_hold), .wrap(wrap), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_pause();
      pause_tgl = 1'b1; step(1); pause_tgl = 1'b0;
   endtask

   task automatic do_tick(input int n);
      tick_run = 1'b1; step(n); tick_run = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v);
      load_val = v; load = 1'b1; step(1); load = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      tick_run = 0; tick_adj = 0; pause_tgl = 0; adj = 0; dir = 0;
      load = 0; lap = 0; sel = 2'd0; load_val = 16'h0000;
      #20;
      chk("rst_count",    32'(count),    32'h0);
      chk("rst_disp",     32'(disp),     32'h0);
      chk("rst_running",  32'(running),  32'h0);
      chk("rst_lap_hold", 32'(lap_hold), 32'h0);
      chk("rst_wrap",     32'(wrap),     32'h0);
      chk("rst_done",     32'(done),     32'h0);
      #2 rst = 1'b0;
      step(1);

      // run 61 seconds -> 01:01
      do_pause();
      chk("run_running", 32'(running), 32'h1);
      do_tick(61);
      chk("run_61", 32'(count), 32'h0101);
      chk("run_61_running", 32'(running), 32'h1);
      // asynchronous reset mid-run, checked before the next clock edge
      rst = 1'b1;
      #2;
      chk("async_rst_count",   32'(count),   32'h0);
      chk("async_rst_running", 32'(running), 32'h0);
      #1 rst = 1'b0;
      step(1);

      // full up-wrap
      do_load(16'h9959);
      chk("load_9959", 32'(count), 32'h9959);
      do_pause();
      do_tick(1);
      chk("wrap_count", 32'(count), 32'h0000);
      chk("wrap_pulse", 32'(wrap),  32'h1);
      step(1);
      chk("wrap_one_cycle", 32'(wrap), 32'h0);
      do_pause();
      chk("stopped", 32'(running), 32'h0);
      do_load(16'h0959);
      do_pause();
      do_tick(1);
      chk("carry_0959", 32'(count), 32'h1000);
      chk("carry_no_wrap", 32'(wrap), 32'h0);
      do_pause();

      // countdown
      dir = 1'b1;
      do_load(16'h0100);
      do_pause();
      do_tick(60);
      chk("down_zero", 32'(count), 32'h0000);
      chk("down_zero_running", 32'(running), 32'h1);
      chk("down_zero_no_done", 32'(done), 32'h0);
      do_tick(1);
      chk("done_pulse",   32'(done),    32'h1);
      chk("done_running", 32'(running), 32'h0);
      chk("done_count",   32'(count),   32'h0000);
      step(1);
      chk("done_one_cycle", 32'(done), 32'h0);
      do_tick(3);
      chk("done_ticks_ignored", 32'(count), 32'h0000);
      do_pause();
      chk("done_to_stop", 32'(running), 32'h0);
      do_pause();
      chk("stop_to_run", 32'(running), 32'h1);
      do_pause();

      // adjust
      dir = 1'b0;
      do_load(16'h0958);
      adj = 1'b1; sel = 2'd0;
      step(1);
      tick_adj = 1'b1; step(2); tick_adj = 1'b0;
      chk("adj_sec_wrap", 32'(count), 32'h0900);
      do_tick(2);
      chk("adj_tick_run_ignored", 32'(count), 32'h0900);
      sel = 2'd1; dir = 1'b1;
      step(1);
      tick_adj = 1'b1; step(10); tick_adj = 1'b0;
      chk("adj_min_down", 32'(count), 32'h9900);
      sel = 2'd3;
      tick_adj = 1'b1; step(1); tick_adj = 1'b0;
      chk("adj_sel_oob", 32'(count), 32'h9900);
      adj = 1'b0;
      step(1);
      chk("adj_exit_running", 32'(running), 32'h0);
      do_pause();
      chk("adj_exit_to_stop", 32'(running), 32'h1);
      do_pause();

      // lap freeze
      dir = 1'b0; sel = 2'd0;
      do_load(16'h0010);
      do_pause();
      step(1);
      lap = 1'b1; step(1); lap = 1'b0;
      chk("lap_hold_set", 32'(lap_hold), 32'h1);
      chk("lap_disp_frozen", 32'(disp), 32'h0010);
      do_tick(5);
      chk("lap_count_moves", 32'(count), 32'h0015);
      chk("lap_disp_still", 32'(disp), 32'h0010);
      lap = 1'b1; step(1); lap = 1'b0;
      chk("lap_released", 32'(lap_hold), 32'h0);
      step(1);
      chk("lap_disp_resumes", 32'(disp), 32'h0015);

      // priority and sanitise
      do_load(16'h4444);
      chk("load_in_run_ignored", 32'(count), 32'h0015);
      do_pause();
      load_val = 16'h1234; load = 1'b1; pause_tgl = 1'b1;
      step(1);
      load = 1'b0; pause_tgl = 1'b0;
      chk("load_beats_pause_count", 32'(count), 32'h1234);
      chk("load_beats_pause_state", 32'(running), 32'h0);
      do_load(16'hA07F);
      chk("sanitise_digits", 32'(count), 32'h9959);
      do_load(16'h0075);
      chk("sanitise_range", 32'(count), 32'h0059);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd_core.md
Name: stopwatch_bcd_core

Overview:
Parametrised BCD stopwatch/timer core. It is the successor to the fixed mm:ss counter and runs on a single clock domain. Timing comes from one-cycle tick enables, not from muxed clocks. Adds NF fields, up/down count, field-selective adjust, preload, countdown-done and lap-freeze display. Sits between the tick/clock-divider block and the 7-segment display driver.

Parameters:
NF, 2, number of 2-digit BCD fields (2..4); field 0 = seconds.
TOP_MAX, 99, maximum value of the top field NF-1 (BCD-decoded integer, 1..99); lower fields are base 60 (00..59).
SELW, 2, width of sel; must satisfy 2**SELW >= NF.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick_run  in  1  one-cycle enable, 1 Hz count tick
tick_adj  in  1  one-cycle enable, 2 Hz adjust tick
pause_tgl  in  1  one-cycle pulse: toggle STOP<->RUN; also clears DONE
adj  in  1  level: adjust mode
sel  in  SELW  field index adjusted while adj=1
dir  in  1  0 = count up, 1 = count down
load  in  1  one-cycle pulse: preload count from load_val
load_val  in  8*NF  BCD preload value, field i at [8i+7:8i] (hi digit [8i+7:8i+4])
lap  in  1  one-cycle pulse: toggle display freeze
count  out  8*NF  live BCD count, same packing as load_val
disp  out  8*NF  registered display value
running  out  1  1 while state = RUN
lap_hold  out  1  1 while display is frozen
wrap  out  1  one-cycle pulse: up-count rolled from all-max to all-zero
done  out  1  one-cycle pulse: countdown reached zero

Behaviour:
- Reset values: count=0, disp=0, state=STOP, running=0, lap_hold=0, wrap=0, done=0. Asserting rst mid-operation aborts everything immediately, without waiting for clk.
- FSM states: STOP, RUN, ADJ, DONE.
  - Any state with adj=1 -> ADJ.
  - ADJ with adj=0 -> STOP.
  - STOP + pause_tgl -> RUN.
  - RUN + pause_tgl -> STOP.
  - RUN, dir=1, tick_run while count==0 -> DONE.
  - DONE + pause_tgl or load -> STOP.
- Per-cycle priority: rst > adj > load > pause_tgl > tick_run. A lower-priority event in the same cycle as a higher one is dropped, not queued.
- RUN, on tick_run, dir=0:
  - Field 0 increments.
  - A field at its max clears to 0 and carries into the next field.
  - Top field wraps TOP_MAX->0.
  - All fields at max -> count=0 and wrap=1 for one cycle.
- RUN, on tick_run, dir=1:
  - Field 0 decrements.
  - A field at 0 borrows and reloads its max (59, or TOP_MAX for the top field).
  - count transitioning to 0 stays in RUN.
  - The next tick_run with count==0 -> state DONE, done=1 for one cycle, count held at 0.
- dir may change at any time; it takes effect on the next tick.
- ADJ, on tick_adj:
  - Only field sel changes: +1 if dir=0, -1 if dir=1.
  - Wraps within its own range with no carry/borrow to other fields.
  - sel >= NF: no change.
  - tick_run ignored.
- load is accepted in STOP or DONE only (ignored in RUN/ADJ). Next cycle count=load_val, with each field sanitised independently:
  - A digit >9 forces that field to its max.
  - A field value above its range forces that field to its max.
- STOP/DONE: count held; ticks ignored.
- Display:
  - disp registers count each cycle (1-cycle latency) while lap_hold=0.
  - lap toggles lap_hold in any state; while lap_hold=1, disp is frozen.
  - On release, disp resumes tracking on the following cycle.
  - rst clears lap_hold.
- Width/arithmetic: all counting is per-digit BCD; count never holds a non-BCD digit.

Test Plan:
- Reset/run, NF=2: rst, pause_tgl, 61 tick_run -> count=16'h0101, running=1; rst mid-run -> count=0, state STOP within same cycle.
- Full up-wrap: load 16'h9959, pause_tgl, tick_run -> count=16'h0000 and wrap pulse exactly one cycle; load 16'h0959 + tick -> 16'h1000.
- Countdown: dir=1, load 16'h0100, pause_tgl, 60 ticks -> 16'h0000 running=1; next tick -> done pulse, running=0, count stays 0; pause_tgl -> STOP.
- Adjust: count 16'h0958, adj=1, sel=0, two tick_adj -> 16'h0900 (no carry into minutes); sel=1, dir=1, 10 tick_adj -> 16'h9900; sel=3 tick -> unchanged; adj=0 -> STOP.
- Lap: running at 16'h0010, lap -> disp frozen at 16'h0010 while count advances to 16'h0015; lap -> disp=16'h0015 one cycle later.
- Priority/sanitise: load in RUN ignored; load with pause_tgl same cycle in STOP -> loaded, stays STOP; load_val 16'hA07F -> count=16'h9959.
